// File: rtl/sp_bram_sched.sv
// sp_bram_sched: credit-based round-robin sharing of one single-port BRAM.
// Optional macro SP_BRAM_SCHED_WR_PRIO_EN gives pending writes priority over reads.
module sp_bram_sched #(
  parameter int N            = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_WIDTH   = 32,
  parameter int WRITE_WIDTH  = 32,
  parameter int WE_WIDTH     = (WRITE_WIDTH + 7) / 8,
  parameter int READ_LATENCY = 2,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N-1:0]                client_req_vld,
  output logic [N-1:0]                client_req_rdy,
  input  logic [N*ADDR_WIDTH-1:0]     client_addr,
  input  logic [N*WRITE_WIDTH-1:0]    client_di,
  input  logic [N*WE_WIDTH-1:0]       client_we,
  output logic [N-1:0]                client_rsp_vld,
  input  logic [N-1:0]                client_rsp_rdy,
  output logic [READ_WIDTH-1:0]       client_rsp_data,
  output logic                        sram_en,
  output logic [WE_WIDTH-1:0]         sram_we,
  output logic [ADDR_WIDTH-1:0]       sram_addr,
  output logic [WRITE_WIDTH-1:0]      sram_di,
  input  logic [READ_WIDTH-1:0]       sram_do,
  output logic [$clog2(RSP_DEPTH+1)-1:0] rd_inflight
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int FW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [N-1:0]          is_wr, elig, cand;
  logic                  credit_ok;
  logic                  win_vld, gnt, issue_rd;
  logic [PW-1:0]         win_idx;
  logic [READ_LATENCY-1:0] pv_q;
  logic [PW-1:0]         pi_q [READ_LATENCY];
  logic [READ_WIDTH-1:0] fd_q [RSP_DEPTH];
  logic [PW-1:0]         fi_q [RSP_DEPTH];
  logic [FW-1:0]         wp_q, rp_q;
  logic [CW-1:0]         cnt_q, infl_q;
  logic                  push, pop, empty;
  logic [PW-1:0]         head_idx;

  assign credit_ok = ({1'b0, cnt_q} + {1'b0, infl_q}) < (CW+1)'(RSP_DEPTH);

  // Eligibility: writes always, reads only while a response slot is reserved.
  always_comb begin
    is_wr = '0;
    elig  = '0;
    for (int i = 0; i < N; i++) begin
      is_wr[i] = |client_we[i*WE_WIDTH +: WE_WIDTH];
      elig[i]  = client_req_vld[i] & (is_wr[i] | credit_ok);
    end
`ifdef SP_BRAM_SCHED_WR_PRIO_EN
    cand = (|(elig & is_wr)) ? (elig & is_wr) : elig;
`else
    cand = elig;
`endif
  end

  // Round-robin pick: first candidate at or after the pointer.
  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!win_vld && cand[j]) begin
        win_vld = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

  assign gnt      = win_vld & ~rst;
  assign issue_rd = gnt & ~is_wr[win_idx];
  assign push     = pv_q[READ_LATENCY-1];
  assign empty    = (cnt_q == '0);
  assign head_idx = fi_q[rp_q];
  assign pop      = ~empty & ~rst & client_rsp_rdy[head_idx];

  // Drive the BRAM port and client handshakes from the winner.
  always_comb begin
    client_req_rdy = '0;
    sram_en        = gnt;
    sram_we        = '0;
    sram_addr      = '0;
    sram_di        = '0;
    ptr_d          = ptr_q;
    if (gnt) begin
      client_req_rdy = N'(1) << win_idx;
      sram_we   = client_we[win_idx*WE_WIDTH +: WE_WIDTH];
      sram_addr = client_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      sram_di   = client_di[win_idx*WRITE_WIDTH +: WRITE_WIDTH];
      ptr_d     = (win_idx == PW'(N-1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Present the FIFO head to its owner.
  always_comb begin
    client_rsp_vld  = '0;
    client_rsp_data = '0;
    if (!empty && !rst) begin
      client_rsp_vld  = N'(1) << head_idx;
      client_rsp_data = fd_q[rp_q];
    end
  end

  assign rd_inflight = rst ? '0 : infl_q;

  // Control state: pointer, read-tracking valids, FIFO pointers and counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      pv_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      infl_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      pv_q[0] <= issue_rd;
      for (int s = 1; s < READ_LATENCY; s++) pv_q[s] <= pv_q[s-1];
      if (push) wp_q <= (wp_q == FW'(RSP_DEPTH-1)) ? '0 : wp_q + 1'b1;
      if (pop)  rp_q <= (rp_q == FW'(RSP_DEPTH-1)) ? '0 : rp_q + 1'b1;
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      infl_q <= infl_q + CW'(issue_rd) - CW'(push);
    end
  end

  // Payload: requester index travels with the read, FIFO captures sram_do.
  always_ff @(posedge clk) begin
    pi_q[0] <= win_idx;
    for (int s = 1; s < READ_LATENCY; s++) pi_q[s] <= pi_q[s-1];
    if (push) begin
      fd_q[wp_q] <= sram_do;
      fi_q[wp_q] <= pi_q[READ_LATENCY-1];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == CW'(RSP_DEPTH)));

endmodule

// File: tb/tb_sp_bram_sched.sv
// tb_sp_bram_sched: directed checks of sp_bram_sched with a 2-cycle BRAM model.
// Honors SP_BRAM_SCHED_WR_PRIO_EN for the write-priority expectations.
module tb_sp_bram_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [31:0]  addr_b;
  logic [127:0] di_b;
  logic [15:0]  we_b;
  logic [31:0]  rsp_data;
  logic         sram_en;
  logic [3:0]   sram_we;
  logic [7:0]   sram_addr;
  logic [31:0]  sram_di, sram_do, rd1;
  logic [2:0]   rd_inflight;
  logic [31:0]  mem [256];
  bit           init_done = 1'b0;
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  sp_bram_sched dut (
    .clk(clk), .rst(rst),
    .client_req_vld(req_vld), .client_req_rdy(req_rdy),
    .client_addr(addr_b), .client_di(di_b), .client_we(we_b),
    .client_rsp_vld(rsp_vld), .client_rsp_rdy(rsp_rdy),
    .client_rsp_data(rsp_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_di(sram_di), .sram_do(sram_do), .rd_inflight(rd_inflight)
  );

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {8'hA5, a, ~a, a};
  endfunction

  // BRAM model: read-first, two-cycle en-to-do latency, byte writes.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
      init_done <= 1'b1;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_di[b*8 +: 8];
      rd1 <= mem[sram_addr];
    end
    sram_do <= rd1;
  end

  task automatic set_cl(input int i, input logic v, input logic [7:0] a,
                        input logic [3:0] w, input logic [31:0] d);
    req_vld[i]      = v;
    addr_b[i*8 +: 8] = a;
    we_b[i*4 +: 4]   = w;
    di_b[i*32 +: 32] = d;
  endtask

  task automatic clr_all();
    req_vld = '0;
    addr_b  = '0;
    we_b    = '0;
    di_b    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_all();
    rsp_rdy = 4'hF;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_all();
    req_vld = 4'hF;
    rsp_rdy = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (req_rdy !== 4'h0) begin
        n_fail++; $display("FAIL reset_rdy c%0d got %h want 0", c, req_rdy);
      end
      n_chk++;
      if (sram_en !== 1'b0 || sram_addr !== 8'h0) begin
        n_fail++; $display("FAIL reset_sram c%0d en %b addr %h", c, sram_en, sram_addr);
      end
      n_chk++;
      if (rsp_vld !== 4'h0 || rd_inflight !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_rsp c%0d vld %h infl %0d", c, rsp_vld, rd_inflight);
      end
      tick();
    end
    rst = 1'b0;
    clr_all();
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) set_cl(i, 1'b1, 8'(8'h20 + i), 4'h0, 32'h0);
    for (int t = 0; t < 12; t++) begin
      #1;
      e = 4'b1 << (t % 4);
      n_chk++;
      if (req_rdy !== e || sram_addr !== 8'(8'h20 + t % 4)) begin
        n_fail++;
        $display("FAIL fair_grant t%0d rdy %h addr %h want %h", t, req_rdy, sram_addr, e);
      end
      if (t >= 3) begin
        e = 4'b1 << ((t - 3) % 4);
        n_chk++;
        if (rsp_vld !== e || rsp_data !== pat(8'(8'h20 + (t - 3) % 4))) begin
          n_fail++;
          $display("FAIL fair_rsp t%0d vld %h data %h want %h", t, rsp_vld, rsp_data, e);
        end
      end else begin
        n_chk++;
        if (rsp_vld !== 4'h0) begin
          n_fail++; $display("FAIL fair_early t%0d vld %h want 0", t, rsp_vld);
        end
      end
      tick();
    end
    clr_all();
    repeat (5) tick();
  endtask

  task automatic test_backpressure();
    int ng;
    logic [3:0] er;
    logic [2:0] ei;
    logic [2:0] infl_tab [14];
    infl_tab = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd0,
                 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
    ng = 0;
    do_reset();
    for (int t = 0; t < 14; t++) begin
      set_cl(1, ng < 5, 8'(8'h30 + ng), 4'h0, 32'h0);
      rsp_rdy = (t >= 8) ? 4'hF : 4'hD;
      #1;
      er = (t < 4 || t == 9) ? 4'h2 : 4'h0;
      n_chk++;
      if (req_rdy !== er) begin
        n_fail++; $display("FAIL bp_grant t%0d got %h want %h", t, req_rdy, er);
      end
      if (req_rdy[1]) ng++;
      ei = infl_tab[t];
      n_chk++;
      if (rd_inflight !== ei) begin
        n_fail++; $display("FAIL bp_infl t%0d got %0d want %0d", t, rd_inflight, ei);
      end
      n_chk++;
      if (t < 3 || t == 13) begin
        if (rsp_vld !== 4'h0 || rsp_data !== 32'h0) begin
          n_fail++; $display("FAIL bp_idle t%0d vld %h data %h", t, rsp_vld, rsp_data);
        end
      end else if (rsp_vld !== 4'h2 ||
                   rsp_data !== pat(8'(8'h30 + ((t < 8) ? 0 : t - 8)))) begin
        n_fail++; $display("FAIL bp_rsp t%0d vld %h data %h", t, rsp_vld, rsp_data);
      end
      tick();
    end
    clr_all();
  endtask

  task automatic test_write_read();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      clr_all();
      if (c == 0) set_cl(0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
      if (c == 5) set_cl(0, 1'b1, 8'h10, 4'h1, 32'h00000055);
      if (c == 1 || c == 6) set_cl(2, 1'b1, 8'h10, 4'h0, 32'h0);
      #1;
      if (c == 0) begin
        n_chk++;
        if (req_rdy !== 4'h1 || sram_we !== 4'hF || sram_di !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL wr_full rdy %h we %h di %h", req_rdy, sram_we, sram_di);
        end
      end
      if (c == 5) begin
        n_chk++;
        if (req_rdy !== 4'h1 || sram_we !== 4'h1) begin
          n_fail++; $display("FAIL wr_part rdy %h we %h want 1/1", req_rdy, sram_we);
        end
      end
      if (c == 1 || c == 6) begin
        n_chk++;
        if (req_rdy !== 4'h4 || sram_we !== 4'h0) begin
          n_fail++; $display("FAIL rd_grant c%0d rdy %h we %h", c, req_rdy, sram_we);
        end
      end
      if (c == 2 || c == 3) begin
        n_chk++;
        if (sram_en !== 1'b0 || rsp_vld !== 4'h0) begin
          n_fail++; $display("FAIL wr_idle c%0d en %b vld %h", c, sram_en, rsp_vld);
        end
      end
      if (c == 4) begin
        n_chk++;
        if (rsp_vld !== 4'h4 || rsp_data !== 32'hDEADBEEF) begin
          n_fail++; $display("FAIL rd_after_wr vld %h data %h want DEADBEEF", rsp_vld, rsp_data);
        end
      end
      if (c == 9) begin
        n_chk++;
        if (rsp_vld !== 4'h4 || rsp_data !== 32'hDEADBE55) begin
          n_fail++; $display("FAIL rd_after_part vld %h data %h want DEADBE55", rsp_vld, rsp_data);
        end
      end
      tick();
    end
    clr_all();
  endtask

  task automatic test_wr_prio();
    logic [3:0] e;
    do_reset();
    for (int t = 0; t < 6; t++) begin
      set_cl(0, 1'b1, 8'h40, 4'h0, 32'h0);
      set_cl(1, 1'b1, 8'h41, 4'h0, 32'h0);
      set_cl(3, 1'b1, 8'h50, 4'hF, 32'(t));
      #1;
`ifdef SP_BRAM_SCHED_WR_PRIO_EN
      e = 4'h8;
`else
      e = (t % 3 == 0) ? 4'h1 : (t % 3 == 1) ? 4'h2 : 4'h8;
`endif
      n_chk++;
      if (req_rdy !== e) begin
        n_fail++; $display("FAIL wr_prio t%0d got %h want %h", t, req_rdy, e);
      end
      tick();
    end
    clr_all();
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    int ng;
    logic [3:0] e;
    do_reset();
    rsp_rdy = 4'h0;
    for (int t = 0; t < 6; t++) begin
      if (t < 4) set_cl(0, 1'b1, 8'(8'h60 + t), 4'h0, 32'h0);
      else clr_all();
      #1;
      if (t == 5) begin
        n_chk++;
        if (rd_inflight !== 3'd1 || rsp_vld !== 4'h1) begin
          n_fail++; $display("FAIL mid_pre infl %0d vld %h want 1/1", rd_inflight, rsp_vld);
        end
      end
      tick();
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (rsp_vld !== 4'h0 || rd_inflight !== 3'd0) begin
      n_fail++; $display("FAIL mid_in_rst vld %h infl %0d", rsp_vld, rd_inflight);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (rsp_vld !== 4'h0 || rd_inflight !== 3'd0) begin
        n_fail++; $display("FAIL mid_post c%0d vld %h infl %0d", c, rsp_vld, rd_inflight);
      end
      tick();
    end
    ng = 0;
    for (int u = 0; u < 7; u++) begin
      set_cl(0, 1'b1, 8'(8'h70 + ng), 4'h0, 32'h0);
      #1;
      e = (u < 4) ? 4'h1 : 4'h0;
      n_chk++;
      if (req_rdy !== e) begin
        n_fail++; $display("FAIL mid_credit u%0d got %h want %h", u, req_rdy, e);
      end
      if (req_rdy[0]) ng++;
      if (u == 3 || u == 6) begin
        n_chk++;
        if (rsp_vld !== 4'h1 || rsp_data !== pat(8'h70)) begin
          n_fail++; $display("FAIL mid_data u%0d vld %h data %h", u, rsp_vld, rsp_data);
        end
      end
      tick();
    end
    clr_all();
    rsp_rdy = 4'hF;
  endtask

  initial begin
    rst = 1'b1;
    rsp_rdy = 4'hF;
    clr_all();
    test_reset();
    test_fairness();
    test_backpressure();
    test_write_read();
    test_wr_prio();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
